hex_pe_quad_ctrl: RTL and testbench

- Sequencer for the four-PE 16-lane MAC cluster.
- Issues IFM/weight buffer reads, one 128-bit beat per cycle, and aligns the PE_reset/PE_finish pulses with data arrival.
- Waits for all four PE valids, then presents the packed 4-channel OFM through a ready/valid output port.
- Repeats for num_pixels output pixels per start, one pixel at a time.

---
 rtl/hex_pe_quad_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_hex_pe_quad_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_pe_quad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hex_pe_quad_ctrl
//  Purpose  : Sequencer for the four-PE 16-lane MAC cluster. Streams one
//             128-bit IFM/weight beat per cycle, aligns PE reset/finish
//             pulses with data arrival, gathers the 4-channel OFM word and
//             hands it out over a ready/valid port, one pixel at a time.
//  Option   : HEX_PE_CTRL_TIMEOUT_EN enables the WAIT-state watchdog (err).
//  Revision : 1.0  initial release
// ============================================================================
module hex_pe_quad_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int CNT_W   = 10,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_chunks,
    input  logic [CNT_W-1:0]  num_pixels,
    output logic              rd_en,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [3:0]        pe_reset,
    output logic [3:0]        pe_finish,
    input  logic [3:0]        pe_valid,
    input  logic [31:0]       ofm_in,
    output logic [31:0]       ofm_data,
    output logic              ofm_valid,
    input  logic              ofm_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_chunks;
    logic [CNT_W-1:0]  r_pixels;
    logic [CNT_W-1:0]  r_chunk;
    logic [CNT_W-1:0]  r_pixel;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_ofm_data;
    logic              r_ofm_valid;

    logic              w_rd_en;
    logic              w_first;
    logic              w_last;
    logic              w_accept;
    logic              w_handshake;
    logic              w_timeout;
    logic              w_last_chunk;
    logic              w_last_pixel;
    logic              w_drained;

    // Per-stage beat flags {beat, first, last}; the last stage lines up with data
    logic [2:0]        w_pipe [RD_LAT];
    logic [RD_LAT-1:0] w_pipe_busy;

    assign w_last_chunk = (r_chunk == r_chunks - c_cnt_one);
    assign w_last_pixel = (r_pixel == r_pixels - c_cnt_one);
    assign w_drained    = ~|w_pipe_busy;

    // Flag delay line: RD_LAT stages so the pulses meet the buffer read data
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                logic [2:0] r_stage;
                // First stage samples the flags of the beat being read now
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) r_stage <= 3'b000;
                    else          r_stage <= {w_rd_en, w_first, w_last};
                end
                assign w_pipe[gi] = r_stage;
            end else begin : g_tail
                logic [2:0] r_stage;
                // Later stages simply shift the previous stage along
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) r_stage <= 3'b000;
                    else          r_stage <= w_pipe[gi-1];
                end
                assign w_pipe[gi] = r_stage;
            end
            assign w_pipe_busy[gi] = w_pipe[gi][2];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_next      = r_state;
        w_rd_en     = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (num_pixels == '0) ? S_FIN : S_FETCH;
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                w_first = (r_chunk == '0);
                w_last  = w_last_chunk;
                if (w_last_chunk) w_next = S_WAIT;
            end
            S_WAIT: begin
                // Results are only trusted once every issued beat has landed
                if (w_timeout) begin
                    w_next = S_FIN;
                end else if (w_drained && (pe_valid == 4'hF)) begin
                    w_accept = 1'b1;
                    w_next   = S_OUT;
                end
            end
            S_OUT: begin
                if (ofm_ready) begin
                    w_handshake = 1'b1;
                    w_next      = w_last_pixel ? S_FIN : S_FETCH;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job counters, address base and the OFM output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chunks    <= '0;
            r_pixels    <= '0;
            r_chunk     <= '0;
            r_pixel     <= '0;
            r_base      <= '0;
            r_ofm_data  <= '0;
            r_ofm_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_chunks <= (num_chunks == '0) ? c_cnt_one : num_chunks;
                        r_pixels <= num_pixels;
                        r_chunk  <= '0;
                        r_pixel  <= '0;
                        r_base   <= '0;
                    end
                end
                S_FETCH: r_chunk <= w_last_chunk ? '0 : r_chunk + c_cnt_one;
                S_WAIT: begin
                    if (w_accept) begin
                        r_ofm_data  <= ofm_in;
                        r_ofm_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_handshake) begin
                        r_ofm_valid <= 1'b0;
                        r_base      <= r_base + ADDR_W'(r_chunks);
                        r_pixel     <= r_pixel + c_cnt_one;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HEX_PE_CTRL_TIMEOUT_EN
    localparam int               c_wd_w     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_pre   = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_wd_w-1:0] c_wd_one   = c_wd_w'(1);

    logic [c_wd_w-1:0] r_wdog;
    logic              r_err;

    // The timeout cycle is the one where the count has reached the limit
    assign w_timeout = (r_state == S_WAIT) && (r_wdog == c_wd_limit);
    assign err       = r_err;

    // Watchdog: count WAIT cycles, raise a sticky error one cycle before abort
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && !w_timeout) r_wdog <= r_wdog + c_wd_one;
            else                                   r_wdog <= '0;
            if ((r_state == S_WAIT) && (r_wdog == c_wd_pre)) r_err <= 1'b1;
        end
    end
`else
    // Without the watchdog WAIT holds indefinitely and err is constant zero
    assign w_timeout = 1'b0;
    assign err       = 1'b0;

    // TIMEOUT has no role here; an illegal value still shows up as a marker scope
    generate
        if (TIMEOUT < 1) begin : g_timeout_unsupported
        end
    endgenerate
`endif

    assign rd_en     = w_rd_en;
    assign ifm_addr  = r_base + ADDR_W'(r_chunk);
    assign wgt_addr  = ADDR_W'(r_chunk);
    assign pe_reset  = {4{w_pipe[RD_LAT-1][1] | w_timeout}};
    assign pe_finish = {4{w_pipe[RD_LAT-1][0]}};
    assign ofm_data  = r_ofm_data;
    assign ofm_valid = r_ofm_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_hex_pe_quad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_pe_quad_ctrl
//  Purpose  : Directed self-checking bench for hex_pe_quad_ctrl (RD_LAT=1).
//             The watchdog scenario is built only with HEX_PE_CTRL_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hex_pe_quad_ctrl;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 10;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              start      = 1'b0;
    logic [CNT_W-1:0]  num_chunks = '0;
    logic [CNT_W-1:0]  num_pixels = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] ifm_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic [3:0]        pe_reset;
    logic [3:0]        pe_finish;
    logic [3:0]        pe_valid   = 4'h0;
    logic [31:0]       ofm_in     = '0;
    logic [31:0]       ofm_data;
    logic              ofm_valid;
    logic              ofm_ready  = 1'b1;
    logic              busy;
    logic              done;
    logic              err;

    int n_err = 0;
    int n_chk = 0;

    hex_pe_quad_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .RD_LAT (1),
        .TIMEOUT(20)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_chunks(num_chunks),
        .num_pixels(num_pixels),
        .rd_en     (rd_en),
        .ifm_addr  (ifm_addr),
        .wgt_addr  (wgt_addr),
        .pe_reset  (pe_reset),
        .pe_finish (pe_finish),
        .pe_valid  (pe_valid),
        .ofm_in    (ofm_in),
        .ofm_data  (ofm_data),
        .ofm_valid (ofm_valid),
        .ofm_ready (ofm_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int chunks, input int pixels);
        num_chunks = CNT_W'(chunks);
        num_pixels = CNT_W'(pixels);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench stopped");
    end

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_ifm_addr", ifm_addr, 0);
        chk("rst_wgt_addr", wgt_addr, 0);
        chk("rst_pe_reset", pe_reset, 0);
        chk("rst_pe_finish", pe_finish, 0);
        chk("rst_ofm_valid", ofm_valid, 0);
        chk("rst_ofm_data", ofm_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;
        tick();

        // ---------------- 1: three chunks, one pixel ----------------
        pulse_start(3, 1);
        chk("t1_rd_en0", rd_en, 1);
        chk("t1_addr0", ifm_addr, 0);
        chk("t1_busy", busy, 1);
        chk("t1_pe_reset_early", pe_reset, 0);
        tick();
        chk("t1_addr1", ifm_addr, 1);
        chk("t1_wgt1", wgt_addr, 1);
        chk("t1_pe_reset", pe_reset, 4'hF);
        chk("t1_pe_finish_early", pe_finish, 0);
        tick();
        chk("t1_addr2", ifm_addr, 2);
        chk("t1_pe_reset_off", pe_reset, 0);
        tick();
        chk("t1_rd_en_off", rd_en, 0);
        chk("t1_pe_finish", pe_finish, 4'hF);
        tick();
        pe_valid = 4'hF;
        ofm_in   = 32'hDEAD_BEEF;
        chk("t1_no_valid_yet", ofm_valid, 0);
        tick();
        pe_valid = 4'h0;
        ofm_in   = 32'h1111_2222;
        chk("t1_ofm_valid", ofm_valid, 1);
        chk("t1_ofm_data", ofm_data, 32'hDEAD_BEEF);
        tick();
        chk("t1_valid_drop", ofm_valid, 0);
        chk("t1_done", done, 1);
        tick();
        chk("t1_done_off", done, 0);
        chk("t1_idle", busy, 0);

        // ---------------- 2: one chunk, four pixels ----------------
        pulse_start(1, 4);
        for (int p = 0; p < 4; p++) begin
            chk("t2_rd_en", rd_en, 1);
            chk("t2_ifm_addr", ifm_addr, p);
            chk("t2_wgt_addr", wgt_addr, 0);
            tick();
            chk("t2_pe_reset", pe_reset, 4'hF);
            chk("t2_pe_finish", pe_finish, 4'hF);
            tick();
            pe_valid = 4'hF;
            ofm_in   = 32'hA0A0_0000 + p;
            tick();
            pe_valid = 4'h0;
            chk("t2_ofm_valid", ofm_valid, 1);
            chk("t2_ofm_data", ofm_data, 32'hA0A0_0000 + p);
            tick();
        end
        chk("t2_done", done, 1);
        chk("t2_valid_off", ofm_valid, 0);
        tick();

        // ---------------- 3: output stall, second pixel base ----------------
        pulse_start(2, 2);
        chk("t3_addr0", ifm_addr, 0);
        tick();
        chk("t3_addr1", ifm_addr, 1);
        tick();
        tick();
        pe_valid = 4'hF;
        ofm_in   = 32'hC0FF_EE01;
        tick();
        pe_valid  = 4'h0;
        ofm_ready = 1'b0;
        ofm_in    = 32'h5555_AAAA;
        chk("t3_ofm_valid", ofm_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_stall_valid", ofm_valid, 1);
            chk("t3_stall_data", ofm_data, 32'hC0FF_EE01);
            chk("t3_stall_rd_en", rd_en, 0);
        end
        ofm_ready = 1'b1;
        tick();
        chk("t3_refetch_rd_en", rd_en, 1);
        chk("t3_refetch_addr", ifm_addr, 2);
        chk("t3_refetch_wgt", wgt_addr, 0);
        chk("t3_valid_off", ofm_valid, 0);
        tick();
        chk("t3_addr3", ifm_addr, 3);
        tick();
        tick();
        pe_valid = 4'hF;
        ofm_in   = 32'hC0FF_EE02;
        tick();
        pe_valid = 4'h0;
        chk("t3_ofm_data2", ofm_data, 32'hC0FF_EE02);
        tick();
        chk("t3_done", done, 1);
        tick();

        // ---------------- 4: partial valid mask ----------------
        pulse_start(1, 1);
        tick();
        tick();
        pe_valid = 4'b0111;
        ofm_in   = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_partial", ofm_valid, 0);
        end
        pe_valid = 4'hF;
        ofm_in   = 32'h600D_F00D;
        tick();
        pe_valid = 4'h0;
        chk("t4_ofm_valid", ofm_valid, 1);
        chk("t4_ofm_data", ofm_data, 32'h600D_F00D);
        tick();
        chk("t4_done", done, 1);
        tick();

        // ---------------- 5: reset mid-job ----------------
        pulse_start(2, 3);
        tick();
        tick();
        tick();
        pe_valid = 4'hF;
        ofm_in   = 32'h0000_0077;
        tick();
        pe_valid = 4'h0;
        tick();
        chk("t5_pix1_rd_en", rd_en, 1);
        chk("t5_pix1_addr", ifm_addr, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_rd_en", rd_en, 0);
        chk("t5_async_addr", ifm_addr, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_ofm_data", ofm_data, 0);
        chk("t5_async_pe_reset", pe_reset, 0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start(2, 1);
        chk("t5_restart_rd_en", rd_en, 1);
        chk("t5_restart_addr", ifm_addr, 0);
        tick();
        tick();
        tick();
        pe_valid = 4'hF;
        ofm_in   = 32'h0000_0088;
        tick();
        pe_valid = 4'h0;
        chk("t5_ofm_data", ofm_data, 32'h0000_0088);
        tick();
        chk("t5_done", done, 1);
        tick();

`ifdef HEX_PE_CTRL_TIMEOUT_EN
        // ---------------- 6: watchdog ----------------
        pulse_start(1, 1);
        tick();
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("t6_err_early", err, 0);
        end
        tick();
        chk("t6_err", err, 1);
        chk("t6_pe_reset", pe_reset, 4'hF);
        chk("t6_done_early", done, 0);
        tick();
        chk("t6_done", done, 1);
        chk("t6_no_ofm", ofm_valid, 0);
        tick();
        chk("t6_err_sticky", err, 1);
        chk("t6_idle", busy, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_err_clear", err, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
